sudoku_peer_checker: RTL and testbench
======================================

Name: sudoku_peer_checker

Overview:
Constraint-check sequencer for the Sudoku solver datapath. On a Start request it scans the board RAM through one synchronous read port and visits all 27 peer positions of a target cell (9 row, 9 column, 9 box). It compares each stored digit against a candidate value. It returns a single Done pulse with a Conflict verdict, and the solver's Check state waits on it.

Parameters:
EARLY_EXIT, 0, 1 = stop scanning at the first detected conflict; 0 = always perform all 27 reads.
ADDR_W, 7, board RAM address width; cell address = Row*9 + Col, range 0..80.

Ports:
Clk  input  1  system clock; all logic on its rising edge.
Reset_n  input  1  synchronous reset, active-low.
Start  input  1  request pulse; sampled only in IDLE.
Row  input  4  target row, 0..8; latched on accepted Start.
Col  input  4  target column, 0..8; latched on accepted Start.
Value  input  4  candidate digit, 1..9; latched on accepted Start.
RdEn  output  1  board RAM read enable.
RdAddr  output  ADDR_W  board RAM read address.
RdData  input  4  RAM read data, valid the cycle after RdEn (0 = empty cell).
Busy  output  1  high from the cycle after Start is accepted through the Done cycle.
Done  output  1  one-cycle completion pulse.
Conflict  output  1  verdict; valid at Done; held until the next accepted Start.
Err  output  1  invalid request (Row>8, Col>8, Value==0 or Value>9); valid at Done; held like Conflict.

Behaviour:
- Reset (Reset_n==0 at a Clk edge): state goes to IDLE. RdEn, RdAddr, Busy, Done, Conflict and Err all go to 0. Reset takes priority over every other input, including mid-scan; a scan aborted by reset produces no Done.
- States: IDLE, SCAN, DRAIN, DONE.
- IDLE: Start=1 latches Row, Col and Value, clears Conflict and Err, then goes to SCAN. If the request is invalid, it goes to DONE instead with Err=1 and Conflict=1, and no RdEn is issued.
- SCAN: 5-bit index k runs 0..26 with RdEn=1 every cycle. RdAddr is registered and changes on the clock edge.
  - k=0..8 (row phase): Row*9 + k.
  - k=9..17 (column phase): (k-9)*9 + Col.
  - k=18..26 (box phase): (br + j/3)*9 + bc + j%3, with j = k-18, br = (Row/3)*3, bc = (Col/3)*3.
  - After k=26, go to DRAIN.
- Compare: in the cycle after each read, a conflict is flagged when RdData==Value, RdData!=0, and the address of that read is not the target cell's own address. The self-match is masked; self reads are still issued. Conflict is sticky.
- DRAIN: one cycle with RdEn=0; compares the data of the last read, then goes to DONE.
- DONE: Done=1 for exactly one cycle, Busy=1, then return to IDLE. Conflict and Err are final in this cycle.
- Timing, EARLY_EXIT=0: Start accepted at edge 0; RdEn high in cycles 1..27; last compare in cycle 28; Done in cycle 29. Latency is fixed at 29 cycles regardless of the data.
- Timing, EARLY_EXIT=1: a match detected in cycle m (from a SCAN or DRAIN compare) moves the FSM directly to DONE, so Done is in cycle m+1. The read issued in cycle m, if any, is ignored and no further RdEn is issued.
- Start while Busy: ignored entirely; latched operands are unchanged.
- Start in the DONE cycle: ignored. Start is accepted again from the first IDLE cycle, which permits back-to-back requests every 30 cycles.
- Arithmetic: Row*9 is formed as (Row<<3)+Row with an ADDR_W-bit result; no out-of-range address is ever driven for valid requests.

Test Plan:
- Empty board (all 0), Start with Row=2, Col=5, Value=7 -> RdEn high for cycles 1..27; addresses 18..26, then 5,14,...,77, then 3,4,5,12,13,14,21,22,23; Done in cycle 29; Conflict=0, Err=0.
- RAM[22]=7 (r2,c4), same request -> Conflict=1 at Done in cycle 29 (EARLY_EXIT=0); with EARLY_EXIT=1, match at cycle 6, so Done is in cycle 7 and RdEn=0 from cycle 7.
- RAM[23]=7 (the target cell itself) only -> Conflict=0; self-masking holds in the row, column and box phases.
- Value=0, then Value=10, then Row=9 -> each gives Done in cycle 1 with Err=1, Conflict=1, and RdEn never asserted.
- Start pulsed at cycle 10 of a scan -> ignored, with latched operands and the address sequence unchanged; drive Reset_n=0 at cycle 15 -> all outputs 0 the next cycle, no Done, and a new Start is then accepted normally.
- Conflict at RAM[72] (r8,c0) for Row=8, Col=8, Value=3 with RAM[72]=3 -> detected in the row phase; verify the box-phase addresses 60,61,62,69,70,71,78,79,80.

Source files
------------

// File: rtl/sudoku_peer_checker.sv
// -----------------------------------------------------------------------------
// sudoku_peer_checker
//
// Constraint-check sequencer for the Sudoku solver datapath. On an accepted
// Start it reads the 27 peer cells of the target (9 row, 9 column, 9 box)
// from the board RAM through one synchronous read port. It compares every
// stored digit with the candidate Value, then returns a single Done pulse
// with a sticky Conflict verdict.
//
// Ports:
//   Clk       in   system clock, rising edge
//   Reset_n   in   synchronous reset, active-low
//   Start     in   request pulse, sampled only while idle
//   Row/Col   in   target cell (0..8), latched on accepted Start
//   Value     in   candidate digit (1..9), latched on accepted Start
//   RdEn      out  board RAM read enable
//   RdAddr    out  board RAM read address (Row*9 + Col), registered
//   RdData    in   RAM data, valid the cycle after RdEn (0 = empty)
//   Busy      out  from the cycle after Start through the Done cycle
//   Done      out  one-cycle completion pulse
//   Conflict  out  verdict, valid at Done, held until the next Start
//   Err       out  invalid request flag, valid at Done, held like Conflict
// -----------------------------------------------------------------------------
module sudoku_peer_checker #(
    parameter int EARLY_EXIT = 0,
    parameter int ADDR_W     = 7
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Start,
    input  logic [3:0]        Row,
    input  logic [3:0]        Col,
    input  logic [3:0]        Value,
    output logic              RdEn,
    output logic [ADDR_W-1:0] RdAddr,
    input  logic [3:0]        RdData,
    output logic              Busy,
    output logic              Done,
    output logic              Conflict,
    output logic              Err
);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN, S_DONE} state_e;

    state_e            state_q, state_d;
    logic [4:0]        k_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [ADDR_W-1:0] cmp_addr_q;
    logic              cmp_valid_q;
    logic [ADDR_W-1:0] self_addr_q;
    logic [3:0]        row_q, col_q, value_q;
    logic              conflict_q, err_q;

    logic req_valid;
    logic match;
    logic hit;

    // x*9 built as (x<<3)+x; valid operands never exceed 80.
    function automatic logic [ADDR_W-1:0] times9(input logic [4:0] x);
        return ADDR_W'({x, 3'b000}) + ADDR_W'(x);
    endfunction

    // Address of peer index k (0..26) for target (r, c).
    function automatic logic [ADDR_W-1:0] peer_addr(input logic [4:0] k,
                                                    input logic [3:0] r,
                                                    input logic [3:0] c);
        logic [4:0] j, jr, jc, br, bc;
        j  = k - 5'd18;
        jr = (j < 5'd3) ? 5'd0 : (j < 5'd6) ? 5'd1 : 5'd2;
        jc = j - jr - jr - jr;
        br = (r < 4'd3) ? 5'd0 : (r < 4'd6) ? 5'd3 : 5'd6;
        bc = (c < 4'd3) ? 5'd0 : (c < 4'd6) ? 5'd3 : 5'd6;
        if (k < 5'd9)
            return times9({1'b0, r}) + ADDR_W'(k);
        else if (k < 5'd18)
            return times9(k - 5'd9) + ADDR_W'(c);
        else
            return times9(br + jr) + ADDR_W'(bc + jc);
    endfunction

    assign req_valid = (Row <= 4'd8) && (Col <= 4'd8) &&
                       (Value != 4'd0) && (Value <= 4'd9);

    // cmp_* describe the read issued last cycle, whose data is on RdData now.
    // The target's own cell is masked out.
    assign match = cmp_valid_q && (RdData == value_q) && (RdData != 4'd0) &&
                   (cmp_addr_q != self_addr_q);
    assign hit   = match && ((state_q == S_SCAN) || (state_q == S_DRAIN));

    // State register
    always_ff @(posedge Clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!Reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        // NOTE: default assignment first so no path leaves state_d unassigned
        // (which would infer a latch).
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (Start) state_d = req_valid ? S_SCAN : S_DONE;
            S_SCAN: begin
                if ((EARLY_EXIT != 0) && hit) state_d = S_DONE;
                else if (k_q == 5'd26)        state_d = S_DRAIN;
            end
            S_DRAIN: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath: operand latch, read address generation, sticky verdict
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            k_q         <= '0;
            rd_addr_q   <= '0;
            cmp_addr_q  <= '0;
            cmp_valid_q <= 1'b0;
            self_addr_q <= '0;
            row_q       <= '0;
            col_q       <= '0;
            value_q     <= '0;
            conflict_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            cmp_valid_q <= (state_q == S_SCAN);
            cmp_addr_q  <= rd_addr_q;
            unique case (state_q)
                S_IDLE: begin
                    if (Start) begin
                        row_q      <= Row;
                        col_q      <= Col;
                        value_q    <= Value;
                        k_q        <= '0;
                        conflict_q <= !req_valid;
                        err_q      <= !req_valid;
                        if (req_valid) begin
                            rd_addr_q   <= peer_addr(5'd0, Row, Col);
                            self_addr_q <= times9({1'b0, Row}) + ADDR_W'(Col);
                        end
                    end
                end
                S_SCAN: begin
                    conflict_q <= conflict_q | match;
                    if (k_q != 5'd26) begin
                        k_q       <= k_q + 5'd1;
                        rd_addr_q <= peer_addr(k_q + 5'd1, row_q, col_q);
                    end
                end
                S_DRAIN: conflict_q <= conflict_q | match;
                default: ;
            endcase
        end
    end

    // Outputs
    always_comb begin
        RdEn     = (state_q == S_SCAN);
        RdAddr   = rd_addr_q;
        Busy     = (state_q != S_IDLE);
        Done     = (state_q == S_DONE);
        Conflict = conflict_q;
        Err      = err_q;
    end

endmodule

// File: tb/tb_sudoku_peer_checker.sv
// -----------------------------------------------------------------------------
// tb_sudoku_peer_checker
//
// Drives two checkers (EARLY_EXIT=0 and EARLY_EXIT=1) from the same request
// stream, each with its own read port onto a shared board image. A reference
// model computes the peer address list, the verdict and the Done cycle
// directly from the Sudoku row/column/box rules.
// -----------------------------------------------------------------------------
module tb_sudoku_peer_checker;

    localparam int ADDR_W = 7;

    logic              Clk = 1'b0;
    logic              Reset_n;
    logic              Start;
    logic [3:0]        Row, Col, Value;

    logic              rd_en0, rd_en1;
    logic [ADDR_W-1:0] rd_addr0, rd_addr1;
    logic [3:0]        rd_data0, rd_data1;
    logic              busy0, busy1, done0, done1;
    logic              conflict0, conflict1, err0, err1;

    logic [3:0] ram [0:80];

    int checks   = 0;
    int failures = 0;

    always #5 Clk = ~Clk;

    sudoku_peer_checker #(.EARLY_EXIT(0), .ADDR_W(ADDR_W)) dut0 (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start),
        .Row(Row), .Col(Col), .Value(Value),
        .RdEn(rd_en0), .RdAddr(rd_addr0), .RdData(rd_data0),
        .Busy(busy0), .Done(done0), .Conflict(conflict0), .Err(err0)
    );

    sudoku_peer_checker #(.EARLY_EXIT(1), .ADDR_W(ADDR_W)) dut1 (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start),
        .Row(Row), .Col(Col), .Value(Value),
        .RdEn(rd_en1), .RdAddr(rd_addr1), .RdData(rd_data1),
        .Busy(busy1), .Done(done1), .Conflict(conflict1), .Err(err1)
    );

    // Synchronous-read board RAM, one port per checker
    always @(posedge Clk) begin
        if (rd_en0) rd_data0 <= (int'(rd_addr0) < 81) ? ram[rd_addr0] : 4'd0;
        if (rd_en1) rd_data1 <= (int'(rd_addr1) < 81) ? ram[rd_addr1] : 4'd0;
    end

    task automatic check(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // k-th peer of (r, c): row cells, then column cells, then box cells.
    function automatic int peer(input int k, input int r, input int c);
        int j;
        if (k < 9)  return r * 9 + k;
        if (k < 18) return (k - 9) * 9 + c;
        j = k - 18;
        return ((r / 3) * 3 + j / 3) * 9 + (c / 3) * 3 + j % 3;
    endfunction

    task automatic clear_board();
        for (int i = 0; i < 81; i++) ram[i] = 4'd0;
    endtask

    // One request; ign_cyc > 0 pulses a decoy Start (different operands)
    // in that cycle of the scan.
    task automatic run_req(input int r, input int c, input int v,
                           input int ign_cyc, input string tag);
        int q0[$];
        int q1[$];
        int done_cyc0, done_cyc1, done_cnt0, done_cnt1, busy_cnt0, busy_cnt1;
        int conf0, conf1, er0, er1, held0, held1;
        int valid, first_hit, exp_done1, exp_reads1, bad0, bad1;

        done_cyc0 = -1; done_cyc1 = -1; done_cnt0 = 0; done_cnt1 = 0;
        busy_cnt0 = 0;  busy_cnt1 = 0;
        conf0 = -1; conf1 = -1; er0 = -1; er1 = -1; held0 = -1; held1 = -1;

        @(negedge Clk);
        Row = 4'(r); Col = 4'(c); Value = 4'(v); Start = 1'b1;
        @(posedge Clk);              // edge 0: request accepted
        #1 Start = 1'b0;
        for (int cyc = 1; cyc <= 31; cyc++) begin
            if (cyc > 1) begin
                @(posedge Clk);
                #1;
            end
            if (cyc == ign_cyc) begin
                Start = 1'b1; Row = 4'd0; Col = 4'd0; Value = 4'd1;
            end else begin
                Start = 1'b0;
            end
            if (rd_en0) q0.push_back(int'(rd_addr0));
            if (rd_en1) q1.push_back(int'(rd_addr1));
            if (busy0) busy_cnt0++;
            if (busy1) busy_cnt1++;
            if (done0) begin
                done_cnt0++; done_cyc0 = cyc; conf0 = int'(conflict0); er0 = int'(err0);
            end
            if (done1) begin
                done_cnt1++; done_cyc1 = cyc; conf1 = int'(conflict1); er1 = int'(err1);
            end
            if (cyc == 31) begin
                held0 = int'(conflict0);
                held1 = int'(conflict1);
            end
        end
        Start = 1'b0;

        // Reference model
        valid = (r <= 8 && c <= 8 && v >= 1 && v <= 9) ? 1 : 0;
        first_hit = -1;
        if (valid != 0) begin
            for (int k = 0; k < 27; k++) begin
                if (first_hit < 0 && peer(k, r, c) != r * 9 + c &&
                    int'(ram[peer(k, r, c)]) == v)
                    first_hit = k;
            end
        end
        if (valid == 0) begin
            exp_done1 = 1; exp_reads1 = 0;
        end else if (first_hit >= 0) begin
            // read in cycle k+1, compare in k+2, Done in k+3
            exp_done1  = first_hit + 3;
            exp_reads1 = (first_hit + 2 < 27) ? first_hit + 2 : 27;
        end else begin
            exp_done1 = 29; exp_reads1 = 27;
        end

        bad0 = 0; bad1 = 0;
        foreach (q0[i]) if (q0[i] != peer(i, r, c)) bad0++;
        foreach (q1[i]) if (q1[i] != peer(i, r, c)) bad1++;

        check({tag, ".done_cycle0"}, done_cyc0, (valid != 0) ? 29 : 1);
        check({tag, ".done_count0"}, done_cnt0, 1);
        check({tag, ".conflict0"},   conf0, (valid == 0 || first_hit >= 0) ? 1 : 0);
        check({tag, ".err0"},        er0, 1 - valid);
        check({tag, ".reads0"},      q0.size(), (valid != 0) ? 27 : 0);
        check({tag, ".addr_bad0"},   bad0, 0);
        check({tag, ".busy_cycles0"}, busy_cnt0, (valid != 0) ? 29 : 1);
        check({tag, ".held0"},       held0, (valid == 0 || first_hit >= 0) ? 1 : 0);
        check({tag, ".done_cycle1"}, done_cyc1, exp_done1);
        check({tag, ".done_count1"}, done_cnt1, 1);
        check({tag, ".conflict1"},   conf1, (valid == 0 || first_hit >= 0) ? 1 : 0);
        check({tag, ".err1"},        er1, 1 - valid);
        check({tag, ".reads1"},      q1.size(), exp_reads1);
        check({tag, ".addr_bad1"},   bad1, 0);
        check({tag, ".busy_cycles1"}, busy_cnt1, exp_done1);
        check({tag, ".held1"},       held1, (valid == 0 || first_hit >= 0) ? 1 : 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".rden"},     int'(rd_en0) + int'(rd_en1), 0);
        check({tag, ".rdaddr"},   int'(rd_addr0) + int'(rd_addr1), 0);
        check({tag, ".busy"},     int'(busy0) + int'(busy1), 0);
        check({tag, ".done"},     int'(done0) + int'(done1), 0);
        check({tag, ".conflict"}, int'(conflict0) + int'(conflict1), 0);
        check({tag, ".err"},      int'(err0) + int'(err1), 0);
    endtask

    initial begin
        int r, c, v, dones;
        Reset_n = 1'b0; Start = 1'b0; Row = '0; Col = '0; Value = '0;
        clear_board();

        // Reset state
        repeat (2) @(posedge Clk);
        #1 check_all_zero("reset");
        @(negedge Clk) Reset_n = 1'b1;

        // Empty board
        run_req(2, 5, 7, 0, "empty");

        // Row-phase conflict at cell 22
        ram[22] = 4'd7;
        run_req(2, 5, 7, 0, "r2c4");

        // Only the target cell holds the value: self-match masked
        clear_board();
        ram[23] = 4'd7;
        run_req(2, 5, 7, 0, "self");

        // Invalid requests
        run_req(2, 5, 0, 0, "val0");
        run_req(2, 5, 10, 0, "val10");
        run_req(9, 5, 7, 0, "row9");
        run_req(2, 12, 7, 0, "col12");

        // Start during a scan is ignored
        clear_board();
        run_req(2, 5, 7, 10, "ignore");

        // Corner target, conflict in the row phase, box at the far corner
        ram[72] = 4'd3;
        run_req(8, 8, 3, 0, "corner");

        // Reset in the middle of a scan
        clear_board();
        ram[22] = 4'd7;
        @(negedge Clk);
        Row = 4'd2; Col = 4'd5; Value = 4'd7; Start = 1'b1;
        @(posedge Clk);
        #1 Start = 1'b0;
        for (int cyc = 2; cyc <= 15; cyc++) begin
            @(posedge Clk);
            #1;
        end
        check("midscan.conflict0", int'(conflict0), 1);
        check("midscan.busy0", int'(busy0), 1);
        Reset_n = 1'b0;              // sampled at edge 15
        @(posedge Clk);
        #1 check_all_zero("midreset");
        Reset_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge Clk);
            #1 dones += int'(done0) + int'(done1);
        end
        check("midreset.no_done", dones, 0);
        run_req(2, 5, 7, 0, "after_reset");

        // Randomized boards and requests
        for (int t = 0; t < 24; t++) begin
            for (int i = 0; i < 81; i++)
                ram[i] = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(1, 9)) : 4'd0;
            r = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 8));
            c = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 8));
            v = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(1, 9));
            run_req(r, c, v, 0, $sformatf("rand%0d", t));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
